// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix scan sequencer: default geometry and FSM state encoding.
package matrix_pkg;

    localparam int DEF_DATAWIDTH    = 8;
    localparam int DEF_ROWS         = 8;
    localparam int DEF_ROWSEL_WIDTH = 3;
    localparam int DEF_LIVES        = 3;
    localparam int DEF_LIVES_WIDTH  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_LOSE  = 3'd5,
        ST_WIN   = 3'd6
    } state_t;

endpackage

// File: rtl/matrix_row_counter.sv
// Row index up-counter with synchronous clear, count enable and a terminal-count flag.
module matrix_row_counter #(
    parameter int WIDTH = 3,
    parameter int LAST  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == WIDTH'(LAST));

endmodule

// File: rtl/matrix_scan_controller.sv
// Game-tick sequencer: scans frog/traffic rows, decides lose/win/continue, pulses the shifter.
// Optional lives counter enabled by defining MATRIXSCAN_LIVES_EN.
//
// state | meaning
// IDLE  | powered up, waiting for start
// WAIT  | game running, waiting for the next tick
// SCAN  | one row per clock, accumulating collisions
// EVAL  | decide lose / win / continue
// SHIFT | one-cycle traffic advance pulse
// LOSE  | game lost, waiting for restart
// WIN   | game won, waiting for restart
module matrix_scan_controller
    import matrix_pkg::*;
#(
    parameter int DATAWIDTH    = DEF_DATAWIDTH,
    parameter int ROWS         = DEF_ROWS,
    parameter int ROWSEL_WIDTH = DEF_ROWSEL_WIDTH,
    parameter int LIVES        = DEF_LIVES,
    parameter int LIVES_WIDTH  = DEF_LIVES_WIDTH
) (
    input  logic                    CC_MATRIXSCAN_CLOCK_50,
    input  logic                    CC_MATRIXSCAN_RESET_InLow,
    input  logic                    CC_MATRIXSCAN_start_InHigh,
    input  logic                    CC_MATRIXSCAN_tick_InHigh,
    input  logic [DATAWIDTH-1:0]    CC_MATRIXSCAN_frogRow_InBUS,
    input  logic [DATAWIDTH-1:0]    CC_MATRIXSCAN_trafficRow_InBUS,
    output logic [ROWSEL_WIDTH-1:0] CC_MATRIXSCAN_rowSel_OutBUS,
    output logic                    CC_MATRIXSCAN_shift_OutHigh,
    output logic                    CC_MATRIXSCAN_frogReset_OutHigh,
    output logic                    CC_MATRIXSCAN_lose_OutHigh,
    output logic                    CC_MATRIXSCAN_win_OutHigh,
    output logic [LIVES_WIDTH-1:0]  CC_MATRIXSCAN_lives_OutBUS,
    output logic [2:0]              CC_MATRIXSCAN_state_OutBUS
);

    // Catch a lives preset that cannot be represented by the counter.
    if (LIVES < 1 || LIVES >= (1 << LIVES_WIDTH)) begin : g_lives_range
        $error("LIVES does not fit in LIVES_WIDTH");
    end

    state_t state, state_nxt;
    logic   hit, top, frog_reset;
    logic   scan_clear, scan_en, row_last;
    logic   restart, life_lost, tick_taken;
    logic   row_hit;

    assign row_hit    = |(CC_MATRIXSCAN_frogRow_InBUS & CC_MATRIXSCAN_trafficRow_InBUS);
    assign tick_taken = (state == ST_WAIT) && CC_MATRIXSCAN_tick_InHigh;

`ifdef MATRIXSCAN_LIVES_EN
    logic [LIVES_WIDTH-1:0] lives;
`endif

    always_comb begin
        state_nxt  = state;
        scan_clear = 1'b0;
        scan_en    = 1'b0;
        restart    = 1'b0;
        life_lost  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (CC_MATRIXSCAN_start_InHigh) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (CC_MATRIXSCAN_tick_InHigh) begin
                    state_nxt  = ST_SCAN;
                    scan_clear = 1'b1;
                end
            end
            ST_SCAN: begin
                if (row_last) state_nxt = ST_EVAL;
                else          scan_en   = 1'b1;
            end
            ST_EVAL: begin
                scan_clear = 1'b1;
                if (hit) begin
`ifdef MATRIXSCAN_LIVES_EN
                    if (lives > LIVES_WIDTH'(1)) begin
                        state_nxt = ST_WAIT;
                        life_lost = 1'b1;
                    end else begin
                        state_nxt = ST_LOSE;
                    end
`else
                    state_nxt = ST_LOSE;
`endif
                end else if (top) begin
                    state_nxt = ST_WIN;
                end else begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: state_nxt = ST_WAIT;
            ST_LOSE, ST_WIN: begin
                if (CC_MATRIXSCAN_start_InHigh) begin
                    state_nxt = ST_WAIT;
                    restart   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CC_MATRIXSCAN_CLOCK_50 or negedge CC_MATRIXSCAN_RESET_InLow) begin
        if (!CC_MATRIXSCAN_RESET_InLow) begin
            state      <= ST_IDLE;
            hit        <= 1'b0;
            top        <= 1'b0;
            frog_reset <= 1'b0;
        end else begin
            state      <= state_nxt;
            frog_reset <= restart | life_lost;
            if (tick_taken || restart) begin
                hit <= 1'b0;
                top <= 1'b0;
            end else if (state == ST_SCAN) begin
                hit <= hit | row_hit;
                if (row_last) top <= |CC_MATRIXSCAN_frogRow_InBUS;
            end
        end
    end

`ifdef MATRIXSCAN_LIVES_EN
    always_ff @(posedge CC_MATRIXSCAN_CLOCK_50 or negedge CC_MATRIXSCAN_RESET_InLow) begin
        if (!CC_MATRIXSCAN_RESET_InLow) begin
            lives <= LIVES_WIDTH'(LIVES);
        end else if (restart) begin
            lives <= LIVES_WIDTH'(LIVES);
        end else if (state == ST_EVAL && hit) begin
            lives <= (lives > LIVES_WIDTH'(1)) ? lives - 1'b1 : '0;
        end
    end

    assign CC_MATRIXSCAN_lives_OutBUS = lives;
`else
    assign CC_MATRIXSCAN_lives_OutBUS = '0;
`endif

    matrix_row_counter #(
        .WIDTH (ROWSEL_WIDTH),
        .LAST  (ROWS - 1)
    ) u_row_counter (
        .clk    (CC_MATRIXSCAN_CLOCK_50),
        .rst_n  (CC_MATRIXSCAN_RESET_InLow),
        .clear  (scan_clear),
        .enable (scan_en),
        .count  (CC_MATRIXSCAN_rowSel_OutBUS),
        .last   (row_last)
    );

    assign CC_MATRIXSCAN_shift_OutHigh     = (state == ST_SHIFT);
    assign CC_MATRIXSCAN_frogReset_OutHigh = frog_reset;
    assign CC_MATRIXSCAN_lose_OutHigh      = (state == ST_LOSE);
    assign CC_MATRIXSCAN_win_OutHigh       = (state == ST_WIN);
    assign CC_MATRIXSCAN_state_OutBUS      = state;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench for matrix_scan_controller; shift pulses are checked against a queue of expected cycles.
module tb_matrix_scan_controller;

`ifdef MATRIXSCAN_LIVES_EN
    localparam int EXP_LIVES = 3;
`else
    localparam int EXP_LIVES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] frog, traffic;
    logic [2:0] row_sel;
    logic       shift, frog_reset, lose, win;
    logic [1:0] lives;
    logic [2:0] state;

    logic [7:0] frog_mem [8];
    logic [7:0] traf_mem [8];

    assign frog    = frog_mem[row_sel];
    assign traffic = traf_mem[row_sel];

    matrix_scan_controller dut (
        .CC_MATRIXSCAN_CLOCK_50          (clk),
        .CC_MATRIXSCAN_RESET_InLow       (rst_n),
        .CC_MATRIXSCAN_start_InHigh      (start),
        .CC_MATRIXSCAN_tick_InHigh       (tick),
        .CC_MATRIXSCAN_frogRow_InBUS     (frog),
        .CC_MATRIXSCAN_trafficRow_InBUS  (traffic),
        .CC_MATRIXSCAN_rowSel_OutBUS     (row_sel),
        .CC_MATRIXSCAN_shift_OutHigh     (shift),
        .CC_MATRIXSCAN_frogReset_OutHigh (frog_reset),
        .CC_MATRIXSCAN_lose_OutHigh      (lose),
        .CC_MATRIXSCAN_win_OutHigh       (win),
        .CC_MATRIXSCAN_lives_OutBUS      (lives),
        .CC_MATRIXSCAN_state_OutBUS      (state)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int exp_shift [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every shift pulse must match the next expected cycle; a surplus pulse finds the queue empty.
    always @(negedge clk) begin
        if (shift === 1'b1) begin
            if (exp_shift.size() == 0) chk("shift_unexpected", 32'(exp_shift.size()), 1);
            else                       chk("shift_cycle", cyc, exp_shift.pop_front());
        end
        if (lose === 1'b1 || win === 1'b1) chk("lose_win_excl", lose & win, 0);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            frog_mem[i] = 8'h00;
            traf_mem[i] = 8'hFF;
        end

        // reset values
        #5;
        chk("rst_state", state, 0);
        chk("rst_rowsel", row_sel, 0);
        chk("rst_shift", shift, 0);
        chk("rst_frogreset", frog_reset, 0);
        chk("rst_lose", lose, 0);
        chk("rst_win", win, 0);
        chk("rst_lives", lives, EXP_LIVES);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("idle_tick_ignored", state, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_to_wait", state, 1);

        // clean scan with heavy traffic but no frog
        tick = 1'b1;
        exp_shift.push_back(cyc + 10);
        step();
        tick = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("scan_row", row_sel, i);
            chk("scan_state", state, 2);
            step();
        end
        chk("eval_state", state, 3);
        step();
        chk("shift_state", state, 4);
        chk("shift_level", shift, 1);
        step();
        chk("after_shift_state", state, 1);
        chk("after_shift_rowsel", row_sel, 0);
        chk("clean_lose", lose, 0);
        chk("clean_win", win, 0);

        // collision on row 3
        for (int i = 0; i < 8; i++) begin
            frog_mem[i] = 8'h00;
            traf_mem[i] = 8'h00;
        end
        frog_mem[3] = 8'h10;
        traf_mem[3] = 8'h10;
`ifdef MATRIXSCAN_LIVES_EN
        for (int n = 0; n < 3; n++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            repeat (9) step();
            if (n < 2) begin
                chk("life_lost_state", state, 1);
                chk("life_lost_frogreset", frog_reset, 1);
                chk("life_lost_lives", lives, 2 - n);
                step();
                chk("life_lost_pulse_end", frog_reset, 0);
            end else begin
                chk("last_life_state", state, 5);
                chk("last_life_lose", lose, 1);
                chk("last_life_lives", lives, 0);
            end
        end
`else
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (9) step();
        chk("hit_state", state, 5);
        chk("hit_lose", lose, 1);
        chk("hit_win", win, 0);
        chk("hit_lives", lives, 0);
`endif
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (3) step();
        chk("lose_tick_ignored", state, 5);
        chk("lose_rowsel_idle", row_sel, 0);

        // start and tick together in LOSE: restart wins
        start = 1'b1;
        tick  = 1'b1;
        step();
        start = 1'b0;
        tick  = 1'b0;
        chk("restart_state", state, 1);
        chk("restart_frogreset", frog_reset, 1);
        chk("restart_lose", lose, 0);
        chk("restart_lives", lives, EXP_LIVES);
        step();
        chk("restart_pulse_end", frog_reset, 0);
        chk("restart_no_scan", state, 1);

        // extra tick during SCAN is dropped
        frog_mem[3] = 8'h00;
        tick = 1'b1;
        exp_shift.push_back(cyc + 10);
        step();
        tick = 1'b0;
        repeat (5) step();
        chk("midscan_row", row_sel, 5);
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (3) step();
        chk("midscan_shift_state", state, 4);
        step();
        repeat (12) step();
        chk("midscan_tick_dropped", state, 1);

        // frog reaches the top row
        frog_mem[7] = 8'h08;
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (9) step();
        chk("win_state", state, 6);
        chk("win_level", win, 1);
        chk("win_lose", lose, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("win_restart_state", state, 1);
        chk("win_restart_win", win, 0);
        chk("win_restart_frogreset", frog_reset, 1);
        chk("win_restart_lives", lives, EXP_LIVES);
        step();
        chk("win_restart_pulse_end", frog_reset, 0);

        // asynchronous reset in the middle of a scan
        frog_mem[7] = 8'h00;
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (4) step();
        chk("pre_abort_row", row_sel, 4);
        chk("pre_abort_state", state, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_state", state, 0);
        chk("abort_rowsel", row_sel, 0);
        chk("abort_shift", shift, 0);
        chk("abort_frogreset", frog_reset, 0);
        chk("abort_lose", lose, 0);
        chk("abort_win", win, 0);
        chk("abort_lives", lives, EXP_LIVES);
        #6;
        rst_n = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (12) step();
        chk("post_abort_idle", state, 0);
        chk("post_abort_rowsel", row_sel, 0);

        repeat (3) step();
        chk("shift_queue_empty", 32'(exp_shift.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
